pbus_router: RTL and testbench
==============================

Name: pbus_router

Overview:
- Registered, parametrised successor to the pCPU combinational memory address mapper.
- Decodes a single CPU master request onto NSLAVE slaves using per-slave base/mask windows, and latches the request.
- Holds the slave strobe until that slave's ready, then returns registered read data with a one-cycle ready pulse.
- Unmapped accesses and non-responding slaves become a bus error (error data plus an irq pulse) instead of hanging the CPU.

Parameters:
- NSLAVE, 8: number of slave ports (1..16).
- SLV_BASE, {NSLAVE{32'h0}}: packed NSLAVE*32 bases; slave i occupies bits [32*i+31:32*i].
- SLV_MASK, {NSLAVE{32'hf0000000}}: packed NSLAVE*32 compare masks. Slave i hits when (a & MASK_i) == (BASE_i & MASK_i).
- TO_W, 16: width of the timeout counter.
- TIMEOUT, 16'd1000: cycles to wait for slave ready. 0 disables the timeout (wait forever).
- ERR_DATA, 32'hdeadbeef: value returned on spo for an errored read.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- a  in  32  master address
- d  in  32  master write data
- we  in  1  master write request
- rd  in  1  master read request
- spo  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- irq  out  1  one-cycle bus-error pulse, coincident with ready
- s_a  out  32  latched address, broadcast to all slaves
- s_d  out  32  latched write data, broadcast
- s_we  out  NSLAVE  per-slave write strobe
- s_rd  out  NSLAVE  per-slave read strobe
- s_spo  in  NSLAVE*32  per-slave read data
- s_ready  in  NSLAVE  per-slave ready (tie 1 for single-cycle slaves)
- err_addr  out  32  captured error address (BUS_ERRLOG_EN only, else 0)
- err_code  out  2  01 = unmapped, 10 = timeout (BUS_ERRLOG_EN only, else 0)
- err_valid  out  1  sticky error flag (BUS_ERRLOG_EN only, else 0)
- err_clr  in  1  clears err_valid (ignored without the macro)

Behaviour:
- Reset (async, immediate): state=IDLE. spo, ready, irq, s_a, s_d, s_we, s_rd, err_* all 0. Timeout counter 0.
- Master handshake: master holds a/d/we/rd stable until it sees ready=1. It must drop rd/we on the cycle after ready or the request is reissued.
- IDLE:
  - Waits for rd|we.
  - On a request, latches a, d, we, rd, and the hit index. The lowest-index matching slave wins.
  - No hit -> ERR with code unmapped.
  - Hit -> ACCESS.
- ACCESS:
  - Drives s_we[idx]=we_l and s_rd[idx]=rd_l & ~we_l; all other strobes 0. rd+we together is a write.
  - On s_ready[idx]=1: latches spo from s_spo[idx] (0 for writes), drops strobes, goes to RESP.
  - Otherwise increments the counter. When counter == TIMEOUT-1 and TIMEOUT != 0: drops strobes, goes to ERR with code timeout.
  - A slave with s_ready tied 1 gives minimum latency: request seen at cycle 0, strobe at cycle 1, ready at cycle 2.
- RESP: ready=1 for exactly one cycle; counter cleared; next state IDLE. A request is accepted again one cycle later, not in RESP.
- ERR: ready=1, irq=1, spo=ERR_DATA for reads (0 for writes), for one cycle; then IDLE. No slave strobe is ever asserted for an unmapped access.
- s_a/s_d update only on IDLE acceptance; stable for the whole transaction.
- TIMEOUT boundary: a slave ready arriving in the same cycle the counter reaches TIMEOUT-1 wins (RESP, not ERR).
- Reset mid-ACCESS: strobes drop asynchronously; the in-flight transaction is discarded with no ready pulse.

Optional Feature:
- Macro: BUS_ERRLOG_EN.
- Defined:
  - On entry to ERR, err_addr and err_code capture the latched address and cause, and err_valid sets, but only if err_valid is currently 0. The first error is preserved.
  - err_clr=1 clears err_valid the next cycle. If an error and err_clr occur in the same cycle, the new error is captured and err_valid stays 1.
- Not defined: err_addr, err_code and err_valid are constant 0; err_clr is unused; the capture logic is absent.

Test Plan:
- Read a=0x10000010, slave1 BASE 0x10000000, s_ready tied 1, s_spo1=0x12345678 -> s_rd[1] high one cycle; ready and spo=0x12345678 exactly two cycles after rd.
- Write a=0x92000004, d=0xa5a5a5a5, slave2 holds s_ready low for 5 cycles -> s_we[2] held for 6 cycles; s_d=0xa5a5a5a5; ready one cycle after s_ready; irq=0.
- Read a=0x70000000 (no window) -> no s_rd bit set; next cycle ready=1, irq=1, spo=0xdeadbeef. With BUS_ERRLOG_EN: err_addr=0x70000000, err_code=01, err_valid=1.
- TIMEOUT=4, slave never ready -> strobe 4 cycles, then ready+irq with code 10. A second error before err_clr leaves err_addr unchanged.
- Overlapping windows on slaves 0 and 3 -> only s_rd[0] asserted.
- rst pulsed while in ACCESS -> s_rd drops with no clock edge; ready never pulses; a new read after reset completes normally.

Source files
------------

// File: rtl/pbus_router.sv
// Registered CPU bus router: decodes one master onto NSLAVE base/mask windows, waits for slave ready,
// and turns unmapped or timed-out accesses into an error response. BUS_ERRLOG_EN adds a sticky error log.
module pbus_router #(
    parameter int                   NSLAVE   = 8,
    parameter logic [NSLAVE*32-1:0] SLV_BASE = {NSLAVE{32'h0}},
    parameter logic [NSLAVE*32-1:0] SLV_MASK = {NSLAVE{32'hf0000000}},
    parameter int                   TO_W     = 16,
    parameter logic [TO_W-1:0]      TIMEOUT  = TO_W'(1000),
    parameter logic [31:0]          ERR_DATA = 32'hdeadbeef
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            a,
    input  logic [31:0]            d,
    input  logic                   we,
    input  logic                   rd,
    output logic [31:0]            spo,
    output logic                   ready,
    output logic                   irq,
    output logic [31:0]            s_a,
    output logic [31:0]            s_d,
    output logic [NSLAVE-1:0]      s_we,
    output logic [NSLAVE-1:0]      s_rd,
    input  logic [NSLAVE*32-1:0]   s_spo,
    input  logic [NSLAVE-1:0]      s_ready,
    output logic [31:0]            err_addr,
    output logic [1:0]             err_code,
    output logic                   err_valid,
    input  logic                   err_clr
);

    localparam int              IDX_W   = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;
    localparam bit              TO_EN   = (TIMEOUT != '0);
    localparam logic [1:0]      CODE_UNMAPPED = 2'b01;
    localparam logic [1:0]      CODE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       d_q, d_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       spo_q, spo_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              err_entry;
    logic [1:0]        err_cause;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        we_d      = we_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        spo_d     = spo_q;
        cnt_d     = cnt_q;
        err_entry = 1'b0;
        err_cause = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (rd || we) begin
                    a_d   = a;
                    d_d   = d;
                    we_d  = we;
                    rd_d  = rd;
                    idx_d = hit_idx;
                    cnt_d = '0;
                    if (hit) begin
                        state_d = ACCESS;
                    end else begin
                        state_d   = ERR;
                        spo_d     = we ? 32'h0 : ERR_DATA;
                        err_entry = 1'b1;
                        err_cause = CODE_UNMAPPED;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked before the timeout so a late-but-on-time slave still wins.
                if (s_ready[idx_q]) begin
                    state_d = RESP;
                    spo_d   = we_q ? 32'h0 : s_spo[32*idx_q +: 32];
                    cnt_d   = '0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = ERR;
                    spo_d     = we_q ? 32'h0 : ERR_DATA;
                    cnt_d     = '0;
                    err_entry = 1'b1;
                    err_cause = CODE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            ERR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            spo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            spo_q   <= spo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode straight off the state register, so an async reset drops them at once.
    always_comb begin
        s_we = '0;
        s_rd = '0;
        if (state_q == ACCESS) begin
            s_we[idx_q] = we_q;
            s_rd[idx_q] = rd_q & ~we_q;
        end
    end

    assign s_a   = a_q;
    assign s_d   = d_q;
    assign spo   = spo_q;
    assign ready = (state_q == RESP) || (state_q == ERR);
    assign irq   = (state_q == ERR);

`ifdef BUS_ERRLOG_EN
    logic [31:0] err_addr_q;
    logic [1:0]  err_code_q;
    logic        err_valid_q;

    // First error sticks until cleared; a clear in the same cycle as a new error lets it in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_q  <= '0;
            err_code_q  <= '0;
            err_valid_q <= 1'b0;
        end else if (err_entry && (!err_valid_q || err_clr)) begin
            err_addr_q  <= a_d;
            err_code_q  <= err_cause;
            err_valid_q <= 1'b1;
        end else if (err_clr) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_code  = err_code_q;
    assign err_valid = err_valid_q;
`else
    logic unused_errlog;
    assign unused_errlog = ^{err_clr, err_entry, err_cause};
    assign err_addr  = '0;
    assign err_code  = '0;
    assign err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pbus_router.sv
// Bench for pbus_router: directed steps then randomized transactions against a window/latency
// reference model; slaves are modelled with a programmable number of not-ready cycles.
module tb_pbus_router;

    localparam int                 NS   = 4;
    localparam logic [15:0]        TO   = 16'd8;
    localparam logic [31:0]        DEAD = 32'hdeadbeef;
    // slave3 .. slave0; slave0 (0x40xxxxxx) overlaps slave3 (0x4xxxxxxx)
    localparam logic [NS*32-1:0]   BASE = {32'h40000000, 32'h90000000, 32'h10000000, 32'h40000000};
    localparam logic [NS*32-1:0]   MASK = {32'hf0000000, 32'hf0000000, 32'hf0000000, 32'hff000000};

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       a, d;
    logic              we, rd;
    logic [31:0]       spo;
    logic              ready, irq;
    logic [31:0]       s_a, s_d;
    logic [NS-1:0]     s_we, s_rd;
    logic [NS*32-1:0]  s_spo;
    logic [NS-1:0]     s_ready;
    logic [31:0]       err_addr;
    logic [1:0]        err_code;
    logic              err_valid;
    logic              err_clr;

    int          lat   [NS];
    logic [31:0] sdata [NS];
    int          scnt  [NS];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pbus_router #(
        .NSLAVE(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .TO_W(16), .TIMEOUT(TO), .ERR_DATA(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .irq(irq), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .err_addr(err_addr), .err_code(err_code), .err_valid(err_valid), .err_clr(err_clr)
    );

    // Slave i answers once it has seen lat[i] strobe cycles.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_ready[i]        = (s_rd[i] | s_we[i]) && (scnt[i] >= lat[i]);
            s_spo[32*i +: 32] = sdata[i];
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) scnt[i] <= 0;
            else     scnt[i] <= (s_rd[i] | s_we[i]) ? scnt[i] + 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one transaction from IDLE and compare it with the model; returns at #1 after
    // the edge following the ready pulse.
    task automatic run(input logic [31:0] ta, input logic [31:0] td,
                       input logic twe, input logic trd, input string tag);
        logic          ehit, eirq, got, oirq;
        int            eidx, ecyc, estb, k, stb_cyc, stb_bad;
        logic [31:0]   espo, ospo, osa, osd;
        logic [NS-1:0] e;
        ehit = 1'b0;
        eidx = 0;
        for (int i = 0; i < NS; i++) begin
            if (!ehit && ((ta & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32]))) begin
                ehit = 1'b1;
                eidx = i;
            end
        end
        if (!ehit) begin
            ecyc = 1; estb = 0; eirq = 1'b1;
        end else if (lat[eidx] < int'(TO)) begin
            ecyc = lat[eidx] + 2; estb = lat[eidx] + 1; eirq = 1'b0;
        end else begin
            ecyc = int'(TO) + 1; estb = int'(TO); eirq = 1'b1;
        end
        espo = twe ? 32'h0 : (eirq ? DEAD : sdata[eidx]);
        e = '0;
        e[eidx] = 1'b1;

        a = ta; d = td; we = twe; rd = trd;
        got = 1'b0; stb_cyc = 0; stb_bad = 0; k = 0;
        ospo = '0; oirq = 1'b0; osa = '0; osd = '0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ready) begin
                got = 1'b1;
                ospo = spo; oirq = irq; osa = s_a; osd = s_d;
                if ((s_rd | s_we) != '0) stb_bad++;
            end else if ((s_rd | s_we) != '0) begin
                stb_cyc++;
                if (!ehit || s_we != (twe ? e : '0) || s_rd != ((trd && !twe) ? e : '0)) stb_bad++;
            end
        end
        we = 1'b0; rd = 1'b0;
        chk({tag, "_got_ready"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(ecyc));
        chk({tag, "_spo"}, ospo, espo);
        chk({tag, "_irq"}, 32'(oirq), 32'(eirq));
        chk({tag, "_s_a"}, osa, ta);
        chk({tag, "_s_d"}, osd, td);
        chk({tag, "_strobe_cycles"}, 32'(stb_cyc), 32'(estb));
        chk({tag, "_strobe_bad"}, 32'(stb_bad), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_ready_one_cycle"}, 32'(ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int npulse;
        logic [3:0] nib;
        logic [31:0] ra;
        int op;
        rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < NS; i++) begin
            lat[i] = 0;
            sdata[i] = 32'h0;
        end
        #12;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_spo", spo, 32'd0);
        chk("reset_strobes", 32'({s_rd, s_we}), 32'd0);
        chk("reset_s_a", s_a, 32'd0);
        chk("reset_s_d", s_d, 32'd0);
        chk("reset_errlog", 32'({err_valid, err_code}) | err_addr, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        lat[1] = 0; sdata[1] = 32'h12345678;
        run(32'h10000010, 32'h0, 1'b0, 1'b1, "rd_fast");

        lat[2] = 5;
        run(32'h92000004, 32'ha5a5a5a5, 1'b1, 1'b0, "wr_wait5");

        run(32'h70000000, 32'h0, 1'b0, 1'b1, "rd_unmapped");
`ifdef BUS_ERRLOG_EN
        chk("log1_addr", err_addr, 32'h70000000);
        chk("log1_code", 32'(err_code), 32'd1);
        chk("log1_valid", 32'(err_valid), 32'd1);
`else
        chk("nolog_addr", err_addr, 32'd0);
        chk("nolog_code_valid", 32'({err_code, err_valid}), 32'd0);
`endif

        lat[1] = 20; sdata[1] = 32'h0badf00d;
        run(32'h10000100, 32'h0, 1'b0, 1'b1, "rd_timeout");
`ifdef BUS_ERRLOG_EN
        chk("log2_addr_kept", err_addr, 32'h70000000);
        chk("log2_code_kept", 32'(err_code), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("log_cleared", 32'(err_valid), 32'd0);
        run(32'h10000200, 32'h0, 1'b0, 1'b1, "rd_timeout2");
        chk("log3_addr", err_addr, 32'h10000200);
        chk("log3_code", 32'(err_code), 32'd2);
        chk("log3_valid", 32'(err_valid), 32'd1);
`else
        chk("nolog_after_timeout", 32'({err_code, err_valid}) | err_addr, 32'd0);
`endif

        lat[1] = int'(TO) - 1; sdata[1] = 32'hcafe0001;
        run(32'h1000000c, 32'h0, 1'b0, 1'b1, "rd_boundary");

        lat[0] = 1; sdata[0] = 32'h00000a00;
        lat[3] = 0; sdata[3] = 32'h00000a03;
        run(32'h40000020, 32'h0, 1'b0, 1'b1, "rd_overlap0");
        run(32'h43000000, 32'h0, 1'b0, 1'b1, "rd_slave3");
        run(32'h40000040, 32'h11112222, 1'b1, 1'b1, "rdwr_is_write");

        // Reset in the middle of an access.
        lat[1] = 20;
        a = 32'h10000008; rd = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_strobe_before", 32'(s_rd), 32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("midrst_strobe_async", 32'({s_rd, s_we}), 32'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        npulse = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready) npulse++;
        end
        chk("midrst_no_ready", 32'(npulse), 32'd0);
        lat[1] = 0; sdata[1] = 32'h77665544;
        run(32'h10000008, 32'h0, 1'b0, 1'b1, "rd_after_rst");

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) begin
                lat[i] = int'($urandom_range(0, 10));
                sdata[i] = $urandom;
            end
            case ($urandom_range(0, 6))
                0: nib = 4'h1;
                1: nib = 4'h4;
                2: nib = 4'h9;
                3: nib = 4'h7;
                4: nib = 4'h0;
                default: nib = 4'($urandom_range(0, 15));
            endcase
            ra = {nib, 28'($urandom)};
            if ($urandom_range(0, 3) == 0) ra[27:24] = 4'h0;
            op = int'($urandom_range(0, 2));
            run(ra, $urandom, (op != 0), (op != 1), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
